mux_v_n_pack: RTL and testbench
===============================

MUX_V_N_PACK -- requirements
Module: mux_v_n_pack

Interface
REQ-001 Parameters: none; all widths come from the shared package.
REQ-002 clk_15_o  in  1  system clock; all logic is on its rising edge.
REQ-003 nrst  in  1  reset, synchronous, active-high.
REQ-004 cod_ce_v  in  1  selects v-mode packing: 6-bit symbols, 5 per word.
REQ-005 cod_ce_n  in  1  selects n-mode packing: 4-bit symbols, 8 per word.
REQ-006 sym_valid  in  1  the current sym_data is valid this cycle.
REQ-007 sym_data  in  6  symbol; v-mode uses [5:0], n-mode uses [3:0].
REQ-008 sym_last  in  1  the accompanying valid symbol is the last symbol of the frame.
REQ-009 rd_done  in  1  downstream decoder has finished reading the frame (its last-data flag).
REQ-010 ram_we  out  1  RX RAM write strobe, one cycle per word.
REQ-011 ram_addr  out  10  RX RAM write address.
REQ-012 ram_wdata  out  32  packed word.
REQ-013 weight_pack  out  16  address of the last word written in the frame.
REQ-014 data_std  out  1  a complete frame is held in RAM.
REQ-015 overflow  out  1  sticky flag: a word or symbol was dropped in this frame.

Function
REQ-016 The FSM SHALL have four states: IDLE, FILL, FLUSH and HOLD.
REQ-017 IDLE: when sym_valid=1, latch the mode (v if cod_ce_v=1, else n if cod_ce_n=1; if neither is set, ignore the symbol), clear overflow, set ram_addr=0, store the symbol in slot 0, and go to FILL.
REQ-018 Slot k SHALL occupy bits [6k+5:6k] in v-mode and [4k+3:4k] in n-mode; unused bits SHALL be 0.
REQ-019 FILL: each valid symbol goes into the next slot. When the last slot (4 in v-mode, 7 in n-mode) is filled, the completed word SHALL be written with ram_we=1 on the next cycle, and the slot counter SHALL wrap to 0.
REQ-020 After each write, ram_addr SHALL increment by 1.
REQ-021 Mode inputs SHALL be ignored after the mode is latched, until the FSM returns to IDLE.
REQ-022 On sym_last, with the symbol stored first: if any slot is filled, go to FLUSH and write the partial word on the next cycle (same cycle timing as a full word); if the symbol completed a word, that write serves as the flush.
REQ-023 FLUSH→HOLD: set weight_pack to the address of the final write, then set data_std=1 one cycle after the final ram_we.
REQ-024 HOLD: data_std=1 and ram_we=0. Valid symbols SHALL be dropped and SHALL set overflow.
REQ-025 In HOLD, rd_done=1 SHALL clear data_std on the next cycle and return the FSM to IDLE. rd_done SHALL be ignored in every other state.
REQ-026 If a word would be written after the write at address 1023, it SHALL be dropped, with no ram_we and no address wrap, and overflow SHALL be set. Symbols SHALL still be consumed until sym_last.
REQ-027 sym_valid with sym_last on the first symbol SHALL produce a one-word frame with weight_pack=0.
REQ-028 ram_we SHALL never be asserted for two words in the same cycle. Symbol throughput SHALL be one per cycle, with no stall.

Reset
REQ-029 While nrst=1, on the next edge: FSM=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, weight_pack=0, data_std=0, overflow=0, slot counter=0, mode cleared.
REQ-030 Reset asserted mid-frame SHALL discard the partial word without any write.

Structure
REQ-031 The shared package SHALL hold RAM_W=32, ADDR_W=10, WP_W=16, SYM_V_W=6, SYM_N_W=4, SLOTS_V=5, SLOTS_N=8, and the FSM state enum.
REQ-032 The block SHALL be a single module with no sub-modules. Slot insertion SHALL be an inline shifted-OR into the word register.

Verification
REQ-033 v-mode, symbols 1..10 with sym_last on 10: writes addr0=0x05103081 and addr1=0x0A2481C6; weight_pack=1; data_std=1 one cycle after the second write.
REQ-034 n-mode, symbols 0xA, 0xB, 0xC with last on 0xC: one write addr0=0x00000CBA; weight_pack=0; data_std=1.
REQ-035 In HOLD, pulse rd_done: data_std=0 on the next cycle. A following frame starts writing at addr 0 with overflow=0.
REQ-036 n-mode, 8200 symbols: writes to addresses 0..1023 only; overflow=1; weight_pack=1023.
REQ-037 nrst=1 after 3 v-mode symbols: no ram_we; all outputs 0 on the next cycle; the next frame starts at addr 0.
REQ-038 cod_ce_v=cod_ce_n=1 at frame start, then cod_ce_v dropped mid-frame: packing stays 6-bit, 5 symbols per word.

Source files
------------

// File: rtl/mux_v_n_pack_pkg.sv
// mux_v_n_pack_pkg: shared widths, slot counts and state types for the symbol packer.
package mux_v_n_pack_pkg;
  localparam int RAM_W   = 32;
  localparam int ADDR_W  = 10;
  localparam int WP_W    = 16;
  localparam int SYM_V_W = 6;
  localparam int SYM_N_W = 4;
  localparam int SLOTS_V = 5;
  localparam int SLOTS_N = 8;
  localparam int SLOT_W  = 3;
  typedef enum logic [1:0] {IDLE, FILL, FLUSH, HOLD} state_e;
  typedef enum logic [1:0] {MODE_NONE, MODE_V, MODE_N} mode_e;
endpackage

// File: rtl/mux_v_n_pack.sv
// mux_v_n_pack: packs 6-bit (v) or 4-bit (n) symbols into 32-bit RX RAM words per frame.
module mux_v_n_pack
  import mux_v_n_pack_pkg::*;
(
  input  logic               clk_15_o,
  input  logic               nrst,
  input  logic               cod_ce_v,
  input  logic               cod_ce_n,
  input  logic               sym_valid,
  input  logic [SYM_V_W-1:0] sym_data,
  input  logic               sym_last,
  input  logic               rd_done,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [RAM_W-1:0]   ram_wdata,
  output logic [WP_W-1:0]    weight_pack,
  output logic               data_std,
  output logic               overflow
);
  state_e             state_q, state_d;
  mode_e              mode_q, mode_d, mode_in, cur_mode;
  logic [SLOT_W-1:0]  slot_q, slot_d, slot_cur, last_slot;
  logic [RAM_W-1:0]   word_q, word_d, wdata_q, wdata_d, sym_ext, word_new;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WP_W-1:0]    weight_q, weight_d;
  logic               full_q, full_d, we_q, we_d, std_q, std_d, ovf_q, ovf_d;
  logic [4:0]         sh;
  logic               is_v, accept, emit, at_top, blocked;
  assign mode_in   = cod_ce_v ? MODE_V : cod_ce_n ? MODE_N : MODE_NONE;
  assign cur_mode  = state_q == IDLE ? mode_in : mode_q;
  assign is_v      = cur_mode == MODE_V;
  assign slot_cur  = state_q == IDLE ? '0 : slot_q;
  assign last_slot = is_v ? SLOT_W'(SLOTS_V - 1) : SLOT_W'(SLOTS_N - 1);
  // slot k starts at bit 6k (v) or 4k (n)
  assign sh        = {slot_cur, 2'b00} + (is_v ? {1'b0, slot_cur, 1'b0} : 5'd0);
  assign sym_ext   = is_v ? RAM_W'(sym_data) : RAM_W'(sym_data[SYM_N_W-1:0]);
  assign word_new  = word_q | (sym_ext << sh);
  assign accept    = sym_valid & (state_q == FILL | (state_q == IDLE & mode_in != MODE_NONE));
  assign emit      = accept & (sym_last | slot_cur == last_slot);
  assign at_top    = addr_q == {ADDR_W{1'b1}};
  // once address 1023 has been written (or is being written now) the RAM is full for this frame
  assign blocked   = state_q != IDLE & (full_q | (we_q & at_top));
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    slot_d   = slot_q;
    word_d   = word_q;
    addr_d   = we_q & ~at_top ? addr_q + 1'b1 : addr_q;
    full_d   = full_q | (we_q & at_top);
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    weight_d = weight_q;
    std_d    = std_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (accept) begin
        mode_d  = mode_in;
        ovf_d   = 1'b0;
        addr_d  = '0;
        full_d  = 1'b0;
        state_d = FILL;
      end
      FLUSH: begin
        weight_d = WP_W'(addr_q);
        std_d    = 1'b1;
        ovf_d    = ovf_q | sym_valid;
        state_d  = HOLD;
      end
      HOLD: begin
        ovf_d   = ovf_q | sym_valid;
        std_d   = ~rd_done;
        state_d = rd_done ? IDLE : HOLD;
      end
      default: ;
    endcase
    if (accept) begin
      slot_d  = emit ? '0 : slot_cur + 1'b1;
      word_d  = emit ? '0 : word_new;
      we_d    = emit & ~blocked;
      wdata_d = emit & ~blocked ? word_new : wdata_q;
      ovf_d   = ovf_d | (emit & blocked);
      state_d = sym_last ? FLUSH : state_d;
    end
  end
  always_ff @(posedge clk_15_o) begin
    if (nrst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_NONE;
      slot_q   <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      full_q   <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      weight_q <= '0;
      std_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      slot_q   <= slot_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      full_q   <= full_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      weight_q <= weight_d;
      std_q    <= std_d;
      ovf_q    <= ovf_d;
    end
  end
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign weight_pack = weight_q;
  assign data_std    = std_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_mux_v_n_pack.sv
// tb_mux_v_n_pack: directed and randomized frames checked against an arithmetic packing model.
module tb_mux_v_n_pack;
  logic        clk_15_o = 1'b0, nrst = 1'b1;
  logic        cod_ce_v = 1'b0, cod_ce_n = 1'b0, sym_valid = 1'b0, sym_last = 1'b0, rd_done = 1'b0;
  logic [5:0]  sym_data = '0;
  logic        ram_we, data_std, overflow;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [15:0] weight_pack;
  int          total = 0, bad = 0;
  int          got_a[$];
  logic [31:0] got_d[$];
  logic [5:0]  frame[$];
  always #5 clk_15_o = ~clk_15_o;
  mux_v_n_pack dut (
    .clk_15_o(clk_15_o), .nrst(nrst), .cod_ce_v(cod_ce_v), .cod_ce_n(cod_ce_n),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last), .rd_done(rd_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .weight_pack(weight_pack), .data_std(data_std), .overflow(overflow)
  );
  always @(negedge clk_15_o)
    if (ram_we) begin
      got_a.push_back(int'(ram_addr));
      got_d.push_back(ram_wdata);
    end
  task automatic tick;
    @(posedge clk_15_o);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic fill_rand(input int n, input bit v);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(6'($urandom_range(0, v ? 63 : 15)));
  endtask
  task automatic run_frame(input bit v, input bit both, input bit gaps);
    int n = frame.size();
    int k = v ? 5 : 8;
    int w = v ? 6 : 4;
    int nw = (n + k - 1) / k;
    int ne = nw > 1024 ? 1024 : nw;
    int lim;
    logic [31:0] exp_w;
    logic [5:0] r;
    got_a.delete();
    got_d.delete();
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        sym_valid = 1'b0;
        {cod_ce_v, cod_ce_n} = 2'($urandom);
        rd_done = 1'($urandom);
        tick;
      end
      r = 6'($urandom);
      sym_valid = 1'b1;
      sym_data = v ? frame[i] : {r[5:4], frame[i][3:0]};
      sym_last = i == n - 1;
      {cod_ce_v, cod_ce_n} = i == 0 ? {v, both | ~v} : 2'($urandom);
      rd_done = 1'($urandom);
      tick;
    end
    sym_valid = 1'b0;
    sym_last = 1'b0;
    rd_done = 1'b0;
    {cod_ce_v, cod_ce_n} = 2'b00;
    chk("flush_we", 32'(ram_we), 32'(nw <= 1024));
    chk("std_early", 32'(data_std), 32'd0);
    tick;
    chk("std", 32'(data_std), 32'd1);
    chk("we_in_hold", 32'(ram_we), 32'd0);
    chk("weight", 32'(weight_pack), 32'(ne - 1));
    chk("ovf", 32'(overflow), 32'(nw > 1024));
    chk("nwrites", 32'(got_a.size()), 32'(ne));
    lim = got_a.size() < ne ? got_a.size() : ne;
    for (int j = 0; j < lim; j++) begin
      exp_w = '0;
      for (int m = j * k; m < n && m < (j + 1) * k; m++)
        exp_w |= (32'(frame[m]) & ((32'd1 << w) - 1)) << (w * (m - j * k));
      chk("addr", 32'(got_a[j]), 32'(j));
      chk("data", got_d[j], exp_w);
    end
  endtask
  task automatic release_hold;
    rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
    chk("rel_std", 32'(data_std), 32'd0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_wp"}, 32'(weight_pack), 32'd0);
    chk({tag, "_std"}, 32'(data_std), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask
  initial begin
    tick;
    tick;
    chk_zero("rst");
    nrst = 1'b0;
    tick;
    frame.delete();
    for (int i = 1; i <= 10; i++) frame.push_back(6'(i));
    run_frame(1'b1, 1'b0, 1'b0);
    chk("v_w0", got_d[0], 32'h05103081);
    chk("v_w1", got_d[1], 32'h0A2481C6);
    chk("v_wp", 32'(weight_pack), 32'd1);
    sym_valid = 1'b1;
    sym_data = 6'h2A;
    tick;
    sym_valid = 1'b0;
    chk("hold_ovf", 32'(overflow), 32'd1);
    chk("hold_we", 32'(ram_we), 32'd0);
    chk("hold_std", 32'(data_std), 32'd1);
    release_hold;
    frame.delete();
    frame.push_back(6'hA);
    frame.push_back(6'hB);
    frame.push_back(6'hC);
    run_frame(1'b0, 1'b0, 1'b0);
    chk("n_w0", got_d[0], 32'h00000CBA);
    chk("n_wp", 32'(weight_pack), 32'd0);
    release_hold;
    fill_rand(1, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0);
    release_hold;
    got_a.delete();
    sym_valid = 1'b1;
    sym_data = 6'h15;
    tick;
    sym_valid = 1'b0;
    tick;
    chk("nomode_nwr", 32'(got_a.size()), 32'd0);
    chk("nomode_std", 32'(data_std), 32'd0);
    for (int f = 0; f < 8; f++) begin
      bit v = 1'($urandom);
      fill_rand($urandom_range(1, 40), v);
      run_frame(v, 1'b0, 1'b1);
      release_hold;
    end
    fill_rand(23, 1'b1);
    run_frame(1'b1, 1'b1, 1'b1);
    release_hold;
    got_a.delete();
    for (int i = 0; i < 3; i++) begin
      sym_valid = 1'b1;
      sym_data = 6'($urandom);
      {cod_ce_v, cod_ce_n} = i == 0 ? 2'b10 : 2'($urandom);
      tick;
    end
    sym_valid = 1'b0;
    {cod_ce_v, cod_ce_n} = 2'b00;
    nrst = 1'b1;
    tick;
    chk_zero("midrst");
    chk("midrst_nwr", 32'(got_a.size()), 32'd0);
    nrst = 1'b0;
    tick;
    fill_rand(7, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    release_hold;
    fill_rand(8200, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    release_hold;
    fill_rand(12, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0);
    release_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
